muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 36 +++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared RV32M funct3 codes, FSM states and special-case constants
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;

  localparam logic [31:0] MD_DIV_OVF_Q = 32'h8000_0000;
  localparam logic [31:0] MD_DIVZ_Q    = 32'hFFFF_FFFF;

  function automatic logic md_src1_signed(input logic [2:0] f3);
    return f3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_src2_signed(input logic [2:0] f3);
    return f3 inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - sign correction and result selection from the magnitude accumulator
module muldiv_sign_fix import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              s1_i,
  input  logic              s2_i,
  input  logic              divz_i,
  input  logic              ovf_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    prod = (s1_i ^ s2_i) ? -acc_i : acc_i;
    quo  = (s1_i ^ s2_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem  = s1_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
    // Divide-by-zero quotient is all ones regardless of the dividend sign
    if (divz_i) quo = MD_DIVZ_Q;
    if (ovf_i) begin
      quo = MD_DIV_OVF_Q;
      rem = '0;
    end
    case (funct3_i)
      MD_MUL:                       result_o = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_o = quo;
      default:                      result_o = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies skip CALC.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            e_in_md_valid,
  input  logic [2:0]      e_in_md_funct3,
  input  logic [XLEN-1:0] e_in_md_src1,
  input  logic [XLEN-1:0] e_in_md_src2,
  input  logic            e_in_kill,
  output logic            e_out_md_busy,
  output logic            e_out_md_done,
  output logic [XLEN-1:0] e_out_md_result
);

  localparam int CW = $clog2(ITER);

  md_state_t         state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              divz_q, divz_d, ovf_q, ovf_d;

  logic              start, in_div, in_s1, in_s2, in_divz, in_ovf;
  logic [XLEN-1:0]   mag1, mag2, fix_result;
  logic [XLEN:0]     mul_sum, div_sh;
  logic              busy, done;

  always_comb begin
    start   = e_in_md_valid & ~e_in_kill;
    in_div  = e_in_md_funct3[2];
    in_s1   = md_src1_signed(e_in_md_funct3) & e_in_md_src1[XLEN-1];
    in_s2   = md_src2_signed(e_in_md_funct3) & e_in_md_src2[XLEN-1];
    mag1    = in_s1 ? -e_in_md_src1 : e_in_md_src1;
    mag2    = in_s2 ? -e_in_md_src2 : e_in_md_src2;
    in_divz = in_div & (e_in_md_src2 == '0);
    in_ovf  = in_div & in_s1 & in_s2 & (e_in_md_src1 == MD_DIV_OVF_Q) & (e_in_md_src2 == '1);
    // Multiply: {hi, multiplier} shifts right; divide: {rem, dividend} shifts left
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_sh  = acc_q[2*XLEN-1:XLEN-1];
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic in_mulz;
  assign in_mulz = ~in_div & ((e_in_md_src1 == '0) | (e_in_md_src2 == '0));
`endif

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy    = 1'b1;
          f3_d    = e_in_md_funct3;
          s1_d    = in_s1;
          s2_d    = in_s2;
          divz_d  = in_divz;
          ovf_d   = in_ovf;
          cnt_d   = '0;
          m_d     = in_div ? mag2 : mag1;
          acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
          state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (in_divz | in_ovf | in_mulz) begin
            state_d = DONE;
            acc_d   = in_divz ? {mag1, MD_DIVZ_Q} :
                      in_ovf  ? {{XLEN{1'b0}}, MD_DIV_OVF_Q} : '0;
          end
`endif
        end
      end
      CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (f3_q[2]) begin
          if (div_sh >= {1'b0, m_q})
            acc_d = {div_sh[XLEN-1:0] - m_q, acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (e_in_kill) begin
      state_d = IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3_i (f3_q),
    .acc_i    (acc_q),
    .s1_i     (s1_q),
    .s2_i     (s2_q),
    .divz_i   (divz_q),
    .ovf_i    (ovf_q),
    .result_o (fix_result)
  );

  assign e_out_md_busy   = busy;
  assign e_out_md_done   = done;
  assign e_out_md_result = done ? fix_result : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench: directed vectors, kill/reset sequences, random ops vs model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic        kill;
  logic        md_busy, md_done;
  logic [31:0] md_result;

  int checks   = 0;
  int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_unit dut (
    .clk             (clk),
    .rst             (rst),
    .e_in_md_valid   (valid),
    .e_in_md_funct3  (funct3),
    .e_in_md_src1    (src1),
    .e_in_md_src2    (src2),
    .e_in_kill       (kill),
    .e_out_md_busy   (md_busy),
    .e_out_md_done   (md_done),
    .e_out_md_result (md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit takes_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sp;
    if (f3[2]) sp = (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       sp = (a == 0) || (b == 0);
    return EARLY && sp;
  endfunction

  // Starts an op at the next negedge (cycle 0) and follows it to its done cycle; valid is left high
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit scramble);
    int lat, busy_n, exp_lat;
    bit nonzero;
    exp_lat = takes_early(f3, a, b) ? 1 : 33;
    lat = -1; busy_n = 0; nonzero = 1'b0;
    @(negedge clk);
    valid = 1'b1; funct3 = f3; src1 = a; src2 = b;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (md_done) begin
        lat = k;
        break;
      end
      if (md_busy) busy_n++;
      if (md_result != 0) nonzero = 1'b1;
      @(negedge clk);
      if (scramble) begin
        src1 = $urandom; src2 = $urandom;
      end
      #1;
    end
    check({name, " done_cycle"}, 32'(lat), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({name, " result_zero_before_done"}, {31'b0, nonzero}, 32'h0);
    check({name, " result"}, md_result, exp);
  endtask

  task automatic watch_no_done(input string name, input int n);
    bit seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      if (md_done) seen = 1'b1;
    end
    check({name, " no_done"}, {31'b0, seen}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF};
    vecs[7]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[8]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
    vecs[13] = '{3'd0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000};
    vecs[14] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};

    rst = 1'b1; valid = 1'b0; kill = 1'b0; funct3 = 3'd0; src1 = 0; src2 = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", {31'b0, md_busy}, 32'h0);
    check("reset done", {31'b0, md_done}, 32'h0);
    check("reset result", md_result, 32'h0);
    rst = 1'b0;

    // Back-to-back: valid stays high from one op into the next
    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // Kill at cycle 10 of a DIV
    @(negedge clk);
    valid = 1'b1; funct3 = 3'd4; src1 = 32'd100; src2 = 32'd7;
    repeat (10) @(negedge clk);
    kill = 1'b1; valid = 1'b0;
    #1;
    check("kill busy", {31'b0, md_busy}, 32'h0);
    check("kill done", {31'b0, md_done}, 32'h0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("after_kill busy", {31'b0, md_busy}, 32'h0);
    watch_no_done("kill", 40);

    // Reset at cycle 20 of a MULHU
    @(negedge clk);
    valid = 1'b1; funct3 = 3'd3; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    repeat (20) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst busy", {31'b0, md_busy}, 32'h0);
    check("after_rst result", md_result, 32'h0);
    watch_no_done("rst", 40);

    run_op("recover", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, ref_md(3'd1, 32'hFFFF_FFFE, 32'h0000_0003), 1'b0);
    valid = 1'b0;

    // Random ops, operands scrambled while the unit is busy
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d f3=%0d a=%08h b=%08h", i, f3, a, b), f3, a, b, ref_md(f3, a, b), 1'b1);
      if ($urandom_range(0, 1) == 0) valid = 1'b0;
    end
    valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
